// File: rtl/pin_sampler_pkg.sv
// rtl/pin_sampler_pkg.sv - register map, command codes and FSM encoding for pin_sampler
//
// Purpose: shared constants for pin_sampler and the firmware header generator.
// Ports:   none (package).

package pin_sampler_pkg;

   localparam int          NUM_REGS   = 6;

   localparam logic [2:0]  OFF_CMD    = 3'd0;
   localparam logic [2:0]  OFF_DIV    = 3'd1;
   localparam logic [2:0]  OFF_COUNT  = 3'd2;
   localparam logic [2:0]  OFF_DATA   = 3'd3;
   localparam logic [2:0]  OFF_STATUS = 3'd4;
   localparam logic [2:0]  OFF_ID     = 3'd5;

   localparam logic [15:0] CMD_START  = 16'd1;
   localparam logic [15:0] CMD_STOP   = 16'd2;
   localparam logic [15:0] CMD_CLEAR  = 16'd3;

   localparam logic [15:0] ID_VALUE   = 16'h5A31;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - 16-bit synchronous FIFO holding packed pin samples
//
// Purpose: word buffer between the sampler and the EBI read side.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   clear               empties the FIFO (both pointers to 0)
//   push, push_data     write request and word; dropped when full
//   pop                 read request; ignored when empty
//   pop_data            current head word
//   full, empty, count  fill status

module sample_fifo #(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  push,
   input  logic [15:0]           push_data,
   input  logic                  pop,
   output logic [15:0]           pop_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   logic [15:0]         mem [2**DEPTH_LOG2];
   logic [DEPTH_LOG2:0] wptr;
   logic [DEPTH_LOG2:0] rptr;
   logic                do_push;
   logic                do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty    = (wptr == rptr);
   assign full     = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                     (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
   assign count    = wptr - rptr;
   assign pop_data = mem[rptr[DEPTH_LOG2-1:0]];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wptr[DEPTH_LOG2-1:0]] <= push_data;
   end

endmodule

// File: rtl/pin_sampler.sv
// rtl/pin_sampler.sv - samples one pin at a programmable rate into a FIFO read over EBI
//
// Purpose: reads a pin back, packs 16 samples per word (bit 15 oldest) and buffers them.
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   enable           EBI chip select (active high)
//   addr             EBI word address; window POSITION..POSITION+5
//   data_wr, data_in EBI write strobe and data
//   data_rd          EBI read strobe
//   data_out         read data; 0 when this block is not addressed
//   pin              sampled pin, asynchronous to clk

module pin_sampler
   import pin_sampler_pkg::*;
#(
   parameter int POSITION   = 0,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [18:0] addr,
   input  logic        data_wr,
   input  logic [15:0] data_in,
   input  logic        data_rd,
   output logic [15:0] data_out,
   input  logic        pin
);

   logic [18:0]         offset;
   logic                hit;
   logic [2:0]          reg_sel;
   logic                en_m, en_s, wr_m, wr_s, rd_m, rd_s, pin_m, pin_s;
   logic                wr_d, rd_d, rd_data_hit;
   logic                wr_act, wr_hit, rd_act, rd_fall;
   logic                cmd_start, cmd_stop, cmd_clear, div_wr;
   state_t              state_q, state_d;
   logic [15:0]         div_reg, div_act, div_cnt, shreg;
   logic [3:0]          bit_cnt;
   logic                push_req, overflow, running;
   logic                fifo_full, fifo_empty, fifo_pop;
   logic [15:0]         fifo_head;
   logic [DEPTH_LOG2:0] fifo_count;

   // Addresses below POSITION wrap to large offsets and miss the window.
   assign offset  = addr - 19'(POSITION);
   assign hit     = (offset < 19'(NUM_REGS));
   assign reg_sel = offset[2:0];

   assign wr_act    = en_s & wr_s;
   assign wr_hit    = wr_act & ~wr_d & hit;
   assign cmd_start = wr_hit && (reg_sel == OFF_CMD) && (data_in == CMD_START);
   assign cmd_stop  = wr_hit && (reg_sel == OFF_CMD) && (data_in == CMD_STOP);
   assign cmd_clear = wr_hit && (reg_sel == OFF_CMD) && (data_in == CMD_CLEAR);
   assign div_wr    = wr_hit && (reg_sel == OFF_DIV);

   assign rd_act   = en_s & rd_s;
   assign rd_fall  = rd_d & ~rd_act;
   assign fifo_pop = rd_fall & rd_data_hit;
   assign running  = (state_q == ST_RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {en_m, en_s, wr_m, wr_s, rd_m, rd_s, pin_m, pin_s} <= '0;
         wr_d        <= 1'b0;
         rd_d        <= 1'b0;
         rd_data_hit <= 1'b0;
      end else begin
         en_m  <= enable;  en_s  <= en_m;
         wr_m  <= data_wr; wr_s  <= wr_m;
         rd_m  <= data_rd; rd_s  <= rd_m;
         pin_m <= pin;     pin_s <= pin_m;
         wr_d  <= wr_act;
         rd_d  <= rd_act;
         // Remember whether the ongoing read targets DATA; the pop fires after the strobe drops.
         if (rd_act) rd_data_hit <= hit && (reg_sel == OFF_DATA);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (cmd_start) state_d = ST_RUN;
         ST_RUN:  if (cmd_stop)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_reg  <= '0;
         div_act  <= '0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         push_req <= 1'b0;
         overflow <= 1'b0;
      end else begin
         push_req <= 1'b0;
         if (div_wr) div_reg <= data_in;

         if (cmd_start) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            div_act <= div_reg;
         end else if (cmd_stop) begin
            div_cnt <= '0;
            bit_cnt <= '0;
         end else if (running) begin
            if (div_cnt == div_act) begin
               // New DIV values are only picked up here, so a period is never cut short.
               div_cnt <= '0;
               div_act <= div_reg;
               shreg   <= {shreg[14:0], pin_s};
               bit_cnt <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd15) push_req <= 1'b1;
            end else begin
               div_cnt <= div_cnt + 16'd1;
            end
         end

         if (cmd_clear)                  overflow <= 1'b0;
         else if (push_req && fifo_full) overflow <= 1'b1;
      end
   end

   sample_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (cmd_clear),
      .push      (push_req),
      .push_data (shreg),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      data_out = 16'h0000;
      if (enable && data_rd && hit) begin
         case (reg_sel)
            OFF_DIV:    data_out = div_reg;
            OFF_COUNT:  data_out = 16'(fifo_count);
            OFF_DATA:   data_out = fifo_empty ? 16'h0000 : fifo_head;
            OFF_STATUS: data_out = {12'b0, overflow, running, fifo_empty, fifo_full};
            OFF_ID:     data_out = ID_VALUE;
            default:    data_out = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_pin_sampler.sv
// tb/tb_pin_sampler.sv - self-checking bench for pin_sampler

module tb_pin_sampler;

   localparam int BASE = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [18:0] addr = '0;
   logic        data_wr = 1'b0;
   logic [15:0] data_in = '0;
   logic        data_rd = 1'b0;
   logic [15:0] data_out;
   logic        pin = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic feed_on = 1'b0;
   logic pin_level = 1'b0;
   int   feed_base = 0;
   int   feed_per = 1;
   logic feed_bits [64];

   pin_sampler #(.POSITION(BASE), .DEPTH_LOG2(6)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .addr     (addr),
      .data_wr  (data_wr),
      .data_in  (data_in),
      .data_rd  (data_rd),
      .data_out (data_out),
      .pin      (pin)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pin for sample k is held for one sample period centred on where that sample lands.
   always @(negedge clk) begin
      int idx;
      idx = 0;
      if (feed_on && cyc >= feed_base) begin
         idx = (cyc - feed_base) / feed_per;
         pin = (idx < 64) ? feed_bits[idx] : pin_level;
      end else begin
         pin = pin_level;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input int off, input logic [15:0] val);
      addr = 19'(BASE + off); data_in = val; enable = 1'b1; data_wr = 1'b1;
      repeat (4) @(negedge clk);
      enable = 1'b0; data_wr = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic bus_read(input int off, input int hold, output logic [15:0] val);
      addr = 19'(BASE + off); enable = 1'b1; data_rd = 1'b1;
      #1 val = data_out;
      repeat (hold) @(negedge clk);
      enable = 1'b0; data_rd = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   function automatic logic [15:0] word_of(input int w);
      logic [15:0] r;
      for (int j = 0; j < 16; j++) r[15-j] = feed_bits[16*w + j];
      return r;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] v;
      int          d;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state and window decode
      bus_read(5, 3, v);  check_eq("id", v, 16'h5A31);
      bus_read(4, 3, v);  check_eq("status_reset", v, 16'h0002);
      bus_read(2, 3, v);  check_eq("count_reset", v, 16'h0000);
      bus_read(1, 3, v);  check_eq("div_reset", v, 16'h0000);
      bus_read(6, 3, v);  check_eq("above_window", v, 16'h0000);
      bus_read(-1, 3, v); check_eq("below_window", v, 16'h0000);

      // Alternating pin with DIV = 3
      for (int i = 0; i < 64; i++) feed_bits[i] = 1'(i % 2);
      feed_per = 4; feed_base = cyc; feed_on = 1'b1;
      bus_write(1, 16'd3);
      bus_write(0, 16'd1);
      repeat (70) @(negedge clk);
      bus_read(2, 3, v); check_eq("alt_count", v, 16'd1);
      bus_write(0, 16'd2);
      bus_read(3, 3, v); check_eq("alt_word", (v == 16'hAAAA || v == 16'h5555), 1'b1);
      bus_read(2, 3, v); check_eq("alt_count_after", v, 16'd0);
      feed_on = 1'b0;

      // Random pin streams, three words each, with a long read strobe on the first word
      for (int run = 0; run < 2; run++) begin
         d = $urandom_range(7, 11);
         for (int i = 0; i < 64; i++) feed_bits[i] = 1'($urandom);
         bus_write(1, 16'(d));
         bus_read(1, 3, v); check_eq("div_readback", v, 32'(d));
         feed_per = d + 1; feed_base = cyc + (d + 1) / 2; feed_on = 1'b1;
         bus_write(0, 16'd1);
         repeat (48 * (d + 1) + 12) @(negedge clk);
         bus_write(0, 16'd2);
         feed_on = 1'b0;
         bus_read(2, 3, v);  check_eq("rnd_count3", v, 16'd3);
         bus_read(3, 20, v); check_eq("rnd_word0", v, word_of(0));
         bus_read(2, 3, v);  check_eq("rnd_count2", v, 16'd2);
         bus_read(3, 3, v);  check_eq("rnd_word1", v, word_of(1));
         bus_read(3, 3, v);  check_eq("rnd_word2", v, word_of(2));
         bus_read(2, 3, v);  check_eq("rnd_count0", v, 16'd0);
         bus_read(3, 3, v);  check_eq("rnd_empty_read", v, 16'h0000);
         bus_read(2, 3, v);  check_eq("rnd_count_still0", v, 16'd0);
         bus_read(4, 3, v);  check_eq("rnd_status_idle", v, 16'h0002);
      end

      // Fill to full, overflow, then clear while running
      pin_level = 1'b1;
      bus_write(1, 16'd0);
      bus_write(0, 16'd1);
      repeat (1024) @(negedge clk);
      bus_read(4, 3, v); check_eq("full_status", v, 16'h0005);
      bus_read(2, 3, v); check_eq("full_count", v, 16'd64);
      repeat (20) @(negedge clk);
      bus_read(4, 3, v); check_eq("ovf_status", v, 16'h000D);
      bus_read(2, 3, v); check_eq("ovf_count", v, 16'd64);
      bus_read(3, 3, v); check_eq("ovf_head", v, 16'hFFFF);
      bus_write(1, 16'd1000);
      bus_write(0, 16'd3);
      bus_read(2, 3, v); check_eq("clear_count", v, 16'd0);
      bus_read(4, 3, v); check_eq("clear_status", v, 16'h0006);
      bus_write(0, 16'd2);

      // Stop mid-word, restart with pin low: partial word must not leak
      bus_write(1, 16'd7);
      bus_write(0, 16'd1);
      repeat (72) @(negedge clk);
      bus_write(0, 16'd2);
      pin_level = 1'b0;
      repeat (10) @(negedge clk);
      bus_write(0, 16'd1);
      repeat (140) @(negedge clk);
      bus_read(2, 3, v); check_eq("restart_count", v, 16'd1);
      bus_read(3, 3, v); check_eq("restart_word", v, 16'h0000);
      bus_write(0, 16'd2);

      // Reset while running with words queued
      pin_level = 1'($urandom);
      bus_write(1, 16'd0);
      bus_write(0, 16'd1);
      repeat (86) @(negedge clk);
      bus_read(2, 3, v); check_eq("pre_reset_count", v, 16'd5);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bus_read(4, 3, v); check_eq("post_reset_status", v, 16'h0002);
      bus_read(2, 3, v); check_eq("post_reset_count", v, 16'd0);
      bus_read(1, 3, v); check_eq("post_reset_div", v, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
